// File: rtl/mux2_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_stream_arbiter
// Description : Packet-level round-robin arbiter for two valid/ready/last
//               streams sharing one output. The registered select S drives
//               an external 2:1 data mux. The grant is held until the LAST
//               beat transfers, and one IDLE cycle follows every packet.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I0_DATA,
    input  logic             I0_VALID,
    input  logic             I0_LAST,
    output logic             I0_READY,
    input  logic [WIDTH-1:0] I1_DATA,
    input  logic             I1_VALID,
    input  logic             I1_LAST,
    output logic             I1_READY,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic             O_LAST,
    input  logic             O_READY,
    output logic             S
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pri;
    logic   pri_nxt;
    logic   sel;
    logic   sel_nxt;
    logic   xfer_last;

    // A packet ends only when its LAST beat actually transfers downstream.
    assign xfer_last = O_VALID && O_READY && O_LAST;

    // State, round-robin pointer and mux select registers with sync reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            pri   <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            pri   <= pri_nxt;
            sel   <= sel_nxt;
        end
    end

    // Next-state logic: arbitrate only in IDLE, release only on LAST transfer.
    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                // I0 wins when alone, or on contention when the pointer favours it.
                if (I0_VALID && (!I1_VALID || !pri)) begin
                    state_nxt = GNT0;
                    sel_nxt   = 1'b0;
                end else if (I1_VALID) begin
                    state_nxt = GNT1;
                    sel_nxt   = 1'b1;
                end
            end
            GNT0: begin
                if (xfer_last) begin
                    state_nxt = IDLE;
                    pri_nxt   = 1'b1;
                end
            end
            GNT1: begin
                if (xfer_last) begin
                    state_nxt = IDLE;
                    pri_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output path: select-driven data mux, handshakes gated by the grant.
    always_comb begin
        O_DATA   = sel ? I1_DATA : I0_DATA;
        O_LAST   = sel ? I1_LAST : I0_LAST;
        O_VALID  = 1'b0;
        I0_READY = 1'b0;
        I1_READY = 1'b0;
        case (state)
            GNT0: begin
                O_VALID  = I0_VALID;
                I0_READY = O_READY;
            end
            GNT1: begin
                O_VALID  = I1_VALID;
                I1_READY = O_READY;
            end
            default: begin
                O_VALID  = 1'b0;
            end
        endcase
    end

    assign S = sel;

endmodule
`default_nettype wire

// File: tb/tb_mux2_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_stream_arbiter
// Description : Vector-table bench for mux2_stream_arbiter with a scoreboard
//               of expected output beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_stream_arbiter;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [WIDTH-1:0] I0_DATA = '0;
    logic             I0_VALID = 1'b0;
    logic             I0_LAST = 1'b0;
    logic             I0_READY;
    logic [WIDTH-1:0] I1_DATA = '0;
    logic             I1_VALID = 1'b0;
    logic             I1_LAST = 1'b0;
    logic             I1_READY;
    logic [WIDTH-1:0] O_DATA;
    logic             O_VALID;
    logic             O_LAST;
    logic             O_READY = 1'b1;
    logic             S;

    mux2_stream_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .I0_DATA  (I0_DATA),
        .I0_VALID (I0_VALID),
        .I0_LAST  (I0_LAST),
        .I0_READY (I0_READY),
        .I1_DATA  (I1_DATA),
        .I1_VALID (I1_VALID),
        .I1_LAST  (I1_LAST),
        .I1_READY (I1_READY),
        .O_DATA   (O_DATA),
        .O_VALID  (O_VALID),
        .O_LAST   (O_LAST),
        .O_READY  (O_READY),
        .S        (S)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       rst;
        bit [7:0] d0;
        bit       v0;
        bit       l0;
        bit [7:0] d1;
        bit       v1;
        bit       l1;
        bit       rdy;
        bit       chk;
        bit       ev;
        bit       er0;
        bit       er1;
        bit       es;
        bit [7:0] ed;
        bit       el;
    } vec_t;

    typedef struct {
        bit [7:0] data;
        bit       last;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic vec_t mk(bit rst, bit [7:0] d0, bit v0, bit l0,
                                bit [7:0] d1, bit v1, bit l1, bit rdy, bit chk,
                                bit ev, bit er0, bit er1, bit es,
                                bit [7:0] ed, bit el);
        vec_t v;
        v.rst = rst; v.d0 = d0; v.v0 = v0; v.l0 = l0;
        v.d1 = d1; v.v1 = v1; v.l1 = l1; v.rdy = rdy; v.chk = chk;
        v.ev = ev; v.er0 = er0; v.er1 = er1; v.es = es; v.ed = ed; v.el = el;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, retire any transfer.
    task automatic run_vec(input vec_t v, input int row);
        beat_t b;
        RST      = v.rst;
        I0_DATA  = v.d0;
        I0_VALID = v.v0;
        I0_LAST  = v.l0;
        I1_DATA  = v.d1;
        I1_VALID = v.v1;
        I1_LAST  = v.l1;
        O_READY  = v.rdy;
        if (v.chk && v.ev && v.rdy && !v.rst) begin
            b.data = v.ed;
            b.last = v.el;
            sb.push_back(b);
        end
        #3;
        if (v.chk) begin
            check("o_valid",  row, 32'(O_VALID),  32'(v.ev));
            check("i0_ready", row, 32'(I0_READY), 32'(v.er0));
            check("i1_ready", row, 32'(I1_READY), 32'(v.er1));
            check("s",        row, 32'(S),        32'(v.es));
            if (v.ev) begin
                check("o_data", row, 32'(O_DATA), 32'(v.ed));
                check("o_last", row, 32'(O_LAST), 32'(v.el));
            end
        end
        if (O_VALID && O_READY && !RST) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected row %0d: got beat %0h expected none", row, O_DATA);
            end else begin
                b = sb.pop_front();
                check("sb_data", row, 32'(O_DATA), 32'(b.data));
                check("sb_last", row, 32'(O_LAST), 32'(b.last));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // rst, d0,v0,l0, d1,v1,l1, rdy, chk, ev,er0,er1,s, ed,el
        // Reset, then I1 sends 0x11,0x12,0x13 and PRI is left at 0.
        vecs.push_back(mk(1, 8'h00,0,0, 8'h00,0,0, 1, 0, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h11,1,0, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h11,1,0, 1, 1, 1,0,1,1, 8'h11,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h12,1,0, 1, 1, 1,0,1,1, 8'h12,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h13,1,1, 1, 1, 1,0,1,1, 8'h13,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,1, 8'h00,0));
        // Both valid with 1-beat packets: grants alternate 0,1,0,1 with IDLE gaps.
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 0,0,0,1, 8'h00,0));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 1,1,0,0, 8'hA0,1));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 1,0,1,1, 8'hB0,1));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 0,0,0,1, 8'h00,0));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 1,1,0,0, 8'hA0,1));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'hA0,1,1, 8'hB0,1,1, 1, 1, 1,0,1,1, 8'hB0,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,1, 8'h00,0));

        // Sequence: 4-beat GNT0 packet with O_READY toggling, I1 waiting.
        vecs.push_back(mk(0, 8'h01,1,0, 8'hB1,1,1, 1, 1, 0,0,0,1, 8'h00,0));
        vecs.push_back(mk(0, 8'h01,1,0, 8'hB1,1,1, 1, 1, 1,1,0,0, 8'h01,0));
        vecs.push_back(mk(0, 8'h02,1,0, 8'hB1,1,1, 0, 1, 1,0,0,0, 8'h02,0));
        vecs.push_back(mk(0, 8'h02,1,0, 8'hB1,1,1, 1, 1, 1,1,0,0, 8'h02,0));
        vecs.push_back(mk(0, 8'h03,1,0, 8'hB1,1,1, 0, 1, 1,0,0,0, 8'h03,0));
        vecs.push_back(mk(0, 8'h03,1,0, 8'hB1,1,1, 1, 1, 1,1,0,0, 8'h03,0));
        vecs.push_back(mk(0, 8'h04,1,1, 8'hB1,1,1, 0, 1, 1,0,0,0, 8'h04,1));
        vecs.push_back(mk(0, 8'h04,1,1, 8'hB1,1,1, 1, 1, 1,1,0,0, 8'h04,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'hB1,1,1, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'hB1,1,1, 1, 1, 1,0,1,1, 8'hB1,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,1, 8'h00,0));

        // Sequence: I0 bubbles for 2 cycles mid-packet, I1 waits for I0 LAST.
        vecs.push_back(mk(0, 8'h21,1,0, 8'hC1,1,1, 1, 1, 0,0,0,1, 8'h00,0));
        vecs.push_back(mk(0, 8'h21,1,0, 8'hC1,1,1, 1, 1, 1,1,0,0, 8'h21,0));
        vecs.push_back(mk(0, 8'h22,0,0, 8'hC1,1,1, 1, 1, 0,1,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h22,0,0, 8'hC1,1,1, 1, 1, 0,1,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h22,1,1, 8'hC1,1,1, 1, 1, 1,1,0,0, 8'h22,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'hC1,1,1, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'hC1,1,1, 1, 1, 1,0,1,1, 8'hC1,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,1, 8'h00,0));

        // Sequence: reset during beat 2 of a GNT1 packet, then I0 wins first.
        vecs.push_back(mk(0, 8'h00,0,0, 8'h31,1,0, 1, 1, 0,0,0,1, 8'h00,0));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h31,1,0, 1, 1, 1,0,1,1, 8'h31,0));
        vecs.push_back(mk(1, 8'h00,0,0, 8'h32,1,0, 1, 1, 1,0,1,1, 8'h32,0));
        vecs.push_back(mk(0, 8'h41,1,1, 8'h33,1,1, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h41,1,1, 8'h33,1,1, 1, 1, 1,1,0,0, 8'h41,1));
        // Sequence: lone I0 request is granted even though PRI favours I1.
        vecs.push_back(mk(0, 8'h51,1,1, 8'h00,0,0, 1, 1, 0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0, 8'h51,1,1, 8'h00,0,0, 1, 1, 1,1,0,0, 8'h51,1));
        vecs.push_back(mk(0, 8'h00,0,0, 8'h00,0,0, 1, 1, 0,0,0,0, 8'h00,0));

        @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        check("sb_drained", vecs.size(), 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
